// File: rtl/uart_pixel_loader.sv
// uart_pixel_loader: 8N1 UART front end that assembles 24-bit pixel packets
// into the image memory and echoes every received byte back on txd.
module uart_pixel_loader #(
    parameter int FREQ       = 100_000_000,
    parameter int BAUD       = 625_000,
    parameter int NUM_PIXELS = 784,
    localparam int AW        = $clog2(NUM_PIXELS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rxd,
    output logic          txd,
    output logic [3:0]    led,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [31:0]   count_packets
);

    localparam int CPB = FREQ / BAUD;
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [9:0]    NPIX_LOC  = 10'(NUM_PIXELS);
    localparam logic [31:0]   NPIX_CNT  = 32'(NUM_PIXELS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    rx_state_t     rx_state_q;
    logic          rxd_s1_q, rxd_s2_q, rxd_s3_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_byte_q;
    logic          rx_valid_q;
    logic          frame_err_q;

    tx_state_t     tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_sh_q;
    logic          txd_q;

    logic [7:0]    fifo_mem_q [4];
    logic [1:0]    wr_ptr_q, wr_ptr_d;
    logic [1:0]    rd_ptr_q, rd_ptr_d;
    logic [2:0]    fifo_cnt_q, fifo_cnt_d;
    logic          fifo_push, tx_pop;

    logic [1:0]    idx_q, idx_d;
    logic [4:0]    b0_q, b0_d;
    logic [7:0]    b1_q, b1_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          pkt_err_q, pkt_err_d;
    logic          recv_done_q, recv_done_d;
    logic          send_done_q, send_done_d;

    logic [20:0]   pkt;
    logic [9:0]    loc;
    logic [7:0]    pix;
    logic [2:0]    footer;

    logic [7:0]    mem_q [NUM_PIXELS];
    logic [7:0]    rd_data_q;

    // Start edge is detected on the synchronised line, then re-checked at mid-bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            rxd_s1_q    <= 1'b1;
            rxd_s2_q    <= 1'b1;
            rxd_s3_q    <= 1'b1;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rxd_s1_q   <= rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_s3_q   <= rxd_s2_q;
            rx_valid_q <= 1'b0;
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (rxd_s3_q && !rxd_s2_q) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rxd_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q  <= '0;
                        rx_byte_q <= {rxd_s2_q, rx_byte_q[7:1]};
                        rx_bit_q  <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                        if (rxd_s2_q) rx_valid_q  <= 1'b1;
                        else          frame_err_q <= 1'b1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign tx_pop    = (tx_state_q == TX_IDLE) && (fifo_cnt_q != 3'd0);
    assign fifo_push = rx_valid_q && ((fifo_cnt_q != 3'd4) || tx_pop);

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem_q[wr_ptr_q] <= rx_byte_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            unique case (tx_state_q)
                TX_IDLE: begin
                    txd_q <= 1'b1;
                    if (tx_pop) begin
                        tx_sh_q    <= fifo_mem_q[rd_ptr_q];
                        tx_cnt_q   <= '0;
                        txd_q      <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        txd_q      <= tx_sh_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        tx_bit_q <= tx_bit_q + 1'b1;
                        if (tx_bit_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_sh_q <= {1'b0, tx_sh_q[7:1]};
                            txd_q   <= tx_sh_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    always_comb begin
        idx_d     = idx_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cnt_d     = cnt_q;
        pkt_err_d = pkt_err_q;
        pkt       = {b0_q, b1_q, rx_byte_q};
        loc       = pkt[20:11];
        pix       = pkt[10:3];
        footer    = {^pix, ^loc, ^{pix[7:4], loc[9:5]}};
        if (rx_valid_q && !fifo_push) pkt_err_d = 1'b1;
        if (rx_valid_q) begin
            unique case (idx_q)
                2'd0: begin
                    if (rx_byte_q[7:5] == 3'b101) begin
                        b0_d  = rx_byte_q[4:0];
                        idx_d = 2'd1;
                    end else begin
                        pkt_err_d = 1'b1;
                    end
                end
                2'd1: begin
                    b1_d  = rx_byte_q;
                    idx_d = 2'd2;
                end
                default: begin
                    idx_d = 2'd0;
                    if (footer == pkt[2:0] && loc < NPIX_LOC) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = loc[AW-1:0];
                        wr_data_d = pix;
                        if (cnt_q != NPIX_CNT) cnt_d = cnt_q + 32'd1;
                    end else begin
                        pkt_err_d = 1'b1;
                    end
                end
            endcase
        end
        wr_ptr_d    = fifo_push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d    = tx_pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q + {2'b0, fifo_push} - {2'b0, tx_pop};
        recv_done_d = recv_done_q | (cnt_q == NPIX_CNT);
        send_done_d = send_done_q | (recv_done_q && fifo_cnt_q == 3'd0
                                     && tx_state_q == TX_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cnt_q       <= '0;
            pkt_err_q   <= 1'b0;
            recv_done_q <= 1'b0;
            send_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            idx_q       <= idx_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cnt_q       <= cnt_d;
            pkt_err_q   <= pkt_err_d;
            recv_done_q <= recv_done_d;
            send_done_q <= send_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // Image memory keeps its contents across reset
    always_ff @(posedge clk) begin
        if (wr_en_q) mem_q[wr_addr_q] <= wr_data_q;
        rd_data_q <= mem_q[rd_addr];
    end

    assign txd           = txd_q;
    assign led           = {frame_err_q, pkt_err_q, send_done_q, recv_done_q};
    assign rd_data       = rd_data_q;
    assign count_packets = cnt_q;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// tb_uart_pixel_loader: random packet stimulus against a byte-level
// reference model of the loader, with a serial echo monitor on txd.
module tb_uart_pixel_loader;

    localparam int FREQ   = 100_000_000;
    localparam int BAUD   = 12_500_000;
    localparam int NPIX   = 32;
    localparam int CPB    = FREQ / BAUD;
    localparam int AW     = $clog2(NPIX);
    localparam int BIT_NS = CPB * 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          rxd;
    logic          txd;
    logic [3:0]    led;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [31:0]   count_packets;

    always #5 clk = ~clk;

    uart_pixel_loader #(
        .FREQ(FREQ),
        .BAUD(BAUD),
        .NUM_PIXELS(NPIX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .txd(txd),
        .led(led),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .count_packets(count_packets)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] echo_q [$];
    logic [7:0] pend_q [$];
    int         m_mem [NPIX];
    int         m_cnt;
    bit         m_perr, m_ferr, m_sdone;
    bit         mon_mute = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int footer_of(input int loc, input int data);
        return ($countones(data) % 2) * 4 + ($countones(loc) % 2) * 2
             + ($countones(data / 16) + $countones(loc / 32)) % 2;
    endfunction

    function automatic logic [23:0] make_pkt(input int loc, input int data);
        return 24'(5 * 2097152 + loc * 2048 + data * 8 + footer_of(loc, data));
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_perr  = 1'b0;
        m_ferr  = 1'b0;
        m_sdone = 1'b0;
        pend_q.delete();
        echo_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        int p, loc, data, f;
        echo_q.push_back(b);
        if (pend_q.size() == 0 && int'(b) / 32 != 5) begin
            m_perr = 1'b1;
            return;
        end
        pend_q.push_back(b);
        if (pend_q.size() < 3) return;
        p = int'(pend_q[0]) * 65536 + int'(pend_q[1]) * 256 + int'(pend_q[2]);
        pend_q.delete();
        loc  = (p / 2048) % 1024;
        data = (p / 8) % 256;
        f    = p % 8;
        if (f == footer_of(loc, data) && loc < NPIX) begin
            m_mem[loc] = data;
            if (m_cnt < NPIX) m_cnt++;
        end else begin
            m_perr = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        if (stop_ok) model_byte(b);
        else m_ferr = 1'b1;
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB + CPB / 2) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [23:0] p);
        send_byte(p[23:16]);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
    endtask

    task automatic drain();
        int k = 0;
        while (echo_q.size() != 0 && k < 40000) begin
            @(negedge clk);
            k++;
        end
        chk("drain", echo_q.size(), 0);
        repeat (CPB + 4) @(negedge clk);
    endtask

    task automatic chk_state(input string tag);
        if (m_cnt == NPIX) m_sdone = 1'b1;
        chk({tag, "_cnt"}, count_packets, 32'(m_cnt));
        chk({tag, "_led"}, {28'h0, led},
            {28'h0, m_ferr, m_perr, m_sdone, m_cnt == NPIX});
    endtask

    task automatic chk_mem(input int a);
        @(negedge clk);
        rd_addr = AW'(a);
        @(negedge clk);
        chk($sformatf("mem%0d", a), {24'h0, rd_data}, 32'(m_mem[a]));
    endtask

    // Serial decoder for the echo line, sampling mid-bit on clk low phase
    initial begin
        logic [7:0] b;
        logic       stop;
        forever begin
            @(negedge txd);
            #(BIT_NS / 2 + 5);
            for (int i = 0; i < 8; i++) begin
                #(BIT_NS);
                b[i] = txd;
            end
            #(BIT_NS);
            stop = txd;
            if (!mon_mute) begin
                chk("echo_stop", {31'h0, stop}, 32'h1);
                if (echo_q.size() == 0) chk("echo_extra", {24'h0, b}, 32'h100);
                else chk("echo", {24'h0, b}, {24'h0, echo_q.pop_front()});
            end
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int off;
        rst     = 1'b1;
        rxd     = 1'b1;
        rd_addr = '0;
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_txd", {31'h0, txd}, 32'h1);
        chk("rst_led", {28'h0, led}, 32'h0);
        chk("rst_cnt", count_packets, 32'h0);

        send_pkt(make_pkt(0, 8'h00));
        drain();
        chk_state("pkt0");
        chk_mem(0);

        send_pkt(make_pkt(5, 8'h3C));
        drain();
        chk_state("pkt5");
        chk_mem(5);

        send_pkt(make_pkt(0, 8'h00) ^ 24'h4);
        drain();
        chk_state("badfoot");
        chk_mem(0);

        send_byte(8'h55);
        send_pkt(make_pkt(7, 8'h9A));
        drain();
        chk_state("resync");
        chk_mem(7);

        send_pkt(make_pkt(NPIX, 8'h11));
        send_pkt(make_pkt(1023, 8'h22));
        drain();
        chk_state("oob");

        off = $urandom_range(0, NPIX - 1);
        for (int i = 0; i < NPIX; i++) begin
            int a;
            a = (i * 7 + off) % NPIX;
            if ($urandom_range(0, 5) == 0)
                send_pkt(make_pkt(a, $urandom_range(0, 255))
                         ^ (24'h1 << $urandom_range(0, 2)));
            if ($urandom_range(0, 7) == 0) send_byte(8'($urandom_range(0, 159)));
            send_pkt(make_pkt(a, $urandom_range(0, 255)));
        end
        drain();
        chk_state("full");
        for (int i = 0; i < NPIX; i++) chk_mem(i);

        send_pkt(make_pkt(3, $urandom_range(0, 255)));
        drain();
        chk_state("sat");
        chk_mem(3);

        send_byte(8'hA0, 1'b0);
        send_pkt(make_pkt(9, $urandom_range(0, 255)));
        drain();
        chk_state("frame");
        chk_mem(9);

        mon_mute = 1'b1;
        send_byte(8'hA0);
        @(negedge clk);
        rxd = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_txd", {31'h0, txd}, 32'h1);
        @(negedge clk);
        chk("mid_rst_led", {28'h0, led}, 32'h0);
        chk("mid_rst_cnt", count_packets, 32'h0);
        rxd = 1'b1;
        rst = 1'b0;
        model_reset();
        repeat (12 * CPB) @(negedge clk);
        mon_mute = 1'b0;
        chk_mem(3);

        send_pkt(make_pkt(20, $urandom_range(0, 255)));
        drain();
        chk_state("post_rst");
        chk_mem(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_pixel_loader.md
Name: uart_pixel_loader

Overview:
- Top-level UART front end of the image-classifier FPGA design.
- Receives 8N1 serial bytes and assembles them into 24-bit pixel packets.
- Validates each packet's header and footer, then stores the pixel byte into a 784-entry image memory.
- Echoes every received byte back on txd; summarises load status on four LEDs.

Parameters:
- FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 625_000, UART bit rate; CLKS_PER_BIT = FREQ/BAUD (160 at defaults).
- NUM_PIXELS, 784, number of image locations / packets per image.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rxd  in  1  UART receive line; idle high; asynchronous to clk.
- txd  out 1  UART transmit line; idle high.
- led  out 4  status: [0] receive_done, [1] send_done, [2] packet_error (sticky), [3] framing_error (sticky).

Behaviour:
- Reset values:
  - txd=1, led=0.
  - count_packets=0, byte index=0, echo FIFO empty, receive_done=0, send_done=0.
  - Pixel memory contents are not cleared.
- UART RX:
  - rxd passes through a 2-FF synchroniser before use.
  - A falling edge starts a byte; the start bit is re-checked low at CLKS_PER_BIT/2, otherwise return to idle.
  - The 8 data bits are sampled LSB first, each at mid-bit.
  - The stop bit is sampled at mid-bit. If high: 1-cycle rx_valid with rx_byte. If low: byte dropped, led[3] set.
- Echo path:
  - Every rx_valid byte is pushed, verbatim, into a 4-deep FIFO, regardless of packet validity.
  - UART TX pops the FIFO when idle and sends start(0), 8 data bits LSB first, stop(1), each CLKS_PER_BIT cycles.
  - Echoed byte order equals received order.
  - Push on a full FIFO drops the byte and sets led[2].
- Packet format: 24 bits MSB-first across bytes.
  - packet = {H[2:0]=3'b101, loc[9:0], data[7:0], F[2:0]}.
  - byte0 = packet[23:16], byte1 = packet[15:8], byte2 = packet[7:0].
- Footer:
  - F[2] = XOR-reduce(data).
  - F[1] = XOR-reduce(loc).
  - F[0] = XOR-reduce({data[7:4], loc[9:5]}).
- Assembler (byte index 0→1→2→0):
  - At index 0, a byte whose [7:5] ≠ 3'b101 is discarded (still echoed), sets led[2], and the index stays 0 (resync).
  - At index 2, the packet is valid iff the footer matches AND loc < NUM_PIXELS.
  - Valid packet: write mem[loc] = data one cycle after the byte2 rx_valid; increment count_packets (32-bit).
  - Invalid packet: no write, no increment, led[2] set; the index still returns to 0.
- Completion flags:
  - receive_done is set, and stays set, when count_packets reaches NUM_PIXELS.
  - Further valid packets still overwrite memory; count_packets saturates at NUM_PIXELS.
  - send_done is set when receive_done=1, the FIFO is empty and TX is idle; it is sticky until rst.
- Memory:
  - 784×8, one synchronous write port.
  - One synchronous read port (addr/data, 1-cycle latency) exported for the downstream NN core.
- Reset mid-byte or mid-packet: the in-flight byte or packet is abandoned, TX immediately drives 1, and the FIFO is flushed.
- Simultaneous rx_valid push and TX pop on the FIFO are both honoured.

Test Plan:
- Reset, then send bytes A0 00 00 (loc 0, data 0x00, F=000) → mem[0]=0x00; count_packets=1; txd echoes A0, 00, 00 each as 10 bits of 1600 ns; led=4'b0000.
- Send A0 29 E0 (loc 5, data 0x3C, F=000) → mem[5]=0x3C; count_packets increments; echo matches byte-for-byte.
- Send A0 00 04 (footer 100 with data 0x00, mismatch) → no memory write; count unchanged; led[2]=1; all three bytes still echoed.
- Send stray byte 0x55 then a valid packet → 0x55 echoed and rejected as header; led[2]=1; the following packet is accepted (resync).
- Send all 784 valid packets, byte gap of 1.5 bit times → every echoed byte equals its sent byte (2352 total); count_packets=784; led[0]=1; led[1]=1 after the last echo stop bit.
- Drive a byte with the stop bit held low → no echo, no assembler advance, led[3]=1; assert rst mid-byte → txd=1, count_packets=0, led=0.
